// File: rtl/sap_control_sequencer.sv
// SAP-U control sequencer: one-hot T1..T5 ring with combinational control decode.
// Optional macro SAP_EARLY_RESET_EN shortens NOP/OUT/LDA by restarting the ring after their last busy step.
module sap_control_sequencer (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       mar_load_n,
  output logic       ram_out_n,
  output logic       ir_load_n,
  output logic       ir_out_n,
  output logic       a_load_n,
  output logic       a_out_n,
  output logic       b_load_n,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_load_n,
  output logic [2:0] step,
  output logic       halted
);

  typedef enum logic [4:0] {
    T1 = 5'b00001,
    T2 = 5'b00010,
    T3 = 5'b00100,
    T4 = 5'b01000,
    T5 = 5'b10000
  } ring_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  ring_t ring;
  logic  legal;
  logic  is_hlt;
  logic  last_step;

  assign legal  = $onehot(ring);
  assign is_hlt = (opcode == OP_HLT);

  always_comb begin
    last_step = (ring == T5);
`ifdef SAP_EARLY_RESET_EN
    // ADD/SUB use all five steps and HLT freezes the ring, so only these shorten.
    if (ring == T3 && opcode != OP_LDA && opcode != OP_ADD &&
        opcode != OP_SUB && opcode != OP_HLT)
      last_step = 1'b1;
    if (ring == T4 && opcode == OP_LDA)
      last_step = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ring   <= T1;
      halted <= 1'b0;
    end else if (!halted) begin
      if (!legal)
        ring <= T1;
      else if (ring == T3 && is_hlt)
        halted <= 1'b1;
      else if (last_step)
        ring <= T1;
      else
        ring <= ring_t'({ring[3:0], 1'b0});
    end
  end

  always_comb begin
    case (ring)
      T1:      step = 3'd1;
      T2:      step = 3'd2;
      T3:      step = 3'd3;
      T4:      step = 3'd4;
      T5:      step = 3'd5;
      default: step = 3'd0;
    endcase
  end

  // Reset, halt and illegal ring patterns all leave every control idle.
  always_comb begin
    pc_inc     = 1'b0;
    pc_out     = 1'b0;
    mar_load_n = 1'b1;
    ram_out_n  = 1'b1;
    ir_load_n  = 1'b1;
    ir_out_n   = 1'b1;
    a_load_n   = 1'b1;
    a_out_n    = 1'b1;
    b_load_n   = 1'b1;
    alu_out    = 1'b0;
    alu_sub    = 1'b0;
    out_load_n = 1'b1;
    if (!clr && !halted) begin
      case (ring)
        T1: begin
          pc_out     = 1'b1;
          mar_load_n = 1'b0;
        end
        T2: begin
          ram_out_n = 1'b0;
          ir_load_n = 1'b0;
          pc_inc    = 1'b1;
        end
        T3: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ir_out_n   = 1'b0;
            mar_load_n = 1'b0;
          end else if (opcode == OP_OUT) begin
            a_out_n    = 1'b0;
            out_load_n = 1'b0;
          end
        end
        T4: begin
          if (opcode == OP_LDA) begin
            ram_out_n = 1'b0;
            a_load_n  = 1'b0;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ram_out_n = 1'b0;
            b_load_n  = 1'b0;
          end
        end
        T5: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out  = 1'b1;
            a_load_n = 1'b0;
            alu_sub  = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench for sap_control_sequencer: directed instructions, halt, mid-instruction reset,
// then random opcodes against an instruction-level reference model.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       pc_inc, pc_out, mar_load_n, ram_out_n, ir_load_n, ir_out_n;
  logic       a_load_n, a_out_n, b_load_n, alu_out, alu_sub, out_load_n;
  logic [2:0] step;
  logic       halted;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the instruction (1..5) and halt status.
  int m_t = 1;
  bit m_halt = 1'b0;
  bit m_valid = 1'b0;
  logic [3:0] cur_op;

  sap_control_sequencer dut (
    .clk(clk), .clr(clr), .opcode(opcode),
    .pc_inc(pc_inc), .pc_out(pc_out), .mar_load_n(mar_load_n),
    .ram_out_n(ram_out_n), .ir_load_n(ir_load_n), .ir_out_n(ir_out_n),
    .a_load_n(a_load_n), .a_out_n(a_out_n), .b_load_n(b_load_n),
    .alu_out(alu_out), .alu_sub(alu_sub), .out_load_n(out_load_n),
    .step(step), .halted(halted)
  );

  always #5 clk = ~clk;

  // Mask bit order: pc_inc pc_out mar_load ram_out ir_load ir_out a_load a_out b_load alu_out alu_sub out_load
  function automatic logic [11:0] exp_mask(input int t, input logic [3:0] op);
    logic [11:0] m;
    m = 12'b0;
    case (t)
      1: m = 12'b0110_0000_0000;
      2: m = 12'b1001_1000_0000;
      3: begin
        if (op == 4'd0 || op == 4'd1 || op == 4'd2) m = 12'b0010_0100_0000;
        else if (op == 4'd14)                        m = 12'b0000_0001_0001;
      end
      4: begin
        if (op == 4'd0)                   m = 12'b0001_0010_0000;
        else if (op == 4'd1 || op == 4'd2) m = 12'b0001_0000_1000;
      end
      5: begin
        if (op == 4'd1)      m = 12'b0000_0010_0100;
        else if (op == 4'd2) m = 12'b0000_0010_0110;
      end
      default: m = 12'b0;
    endcase
    return m;
  endfunction

  function automatic int instr_len(input logic [3:0] op);
`ifdef SAP_EARLY_RESET_EN
    if (op == 4'd1 || op == 4'd2) return 5;
    if (op == 4'd0) return 4;
    return 3;
`else
    return 5;
`endif
  endfunction

  task automatic checkOutput();
    logic [11:0] obs;
    logic [11:0] exp;
    int drivers;
    obs = {pc_inc, pc_out, ~mar_load_n, ~ram_out_n, ~ir_load_n, ~ir_out_n,
           ~a_load_n, ~a_out_n, ~b_load_n, alu_out, alu_sub, ~out_load_n};
    exp = (clr || m_halt || !m_valid) ? 12'b0 : exp_mask(m_t, opcode);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL controls t=%0d op=%b observed=%b expected=%b", m_t, opcode, obs, exp);
    end
    drivers = int'(pc_out) + int'(!ram_out_n) + int'(!ir_out_n) + int'(!a_out_n) + int'(alu_out);
    checks++;
    assert (drivers <= 1) else begin
      errors++;
      $error("[TB] FAIL bus_excl observed=%0d drivers expected<=1", drivers);
    end
    if (m_valid) begin
      checks++;
      assert (step === 3'(m_halt ? 3 : m_t)) else begin
        errors++;
        $error("[TB] FAIL step observed=%0d expected=%0d", step, m_halt ? 3 : m_t);
      end
      checks++;
      assert (halted === m_halt) else begin
        errors++;
        $error("[TB] FAIL halted observed=%b expected=%b", halted, m_halt);
      end
    end
  endtask

  task automatic applyStimulus(input logic c, input logic [3:0] op);
    @(negedge clk);
    clr = c;
    opcode = op;
    #1;
    checkOutput();
    @(posedge clk);
    if (clr) begin
      m_t = 1;
      m_halt = 1'b0;
      m_valid = 1'b1;
    end else if (!m_halt) begin
      if (m_t == 3 && opcode == 4'd15) m_halt = 1'b1;
      else if (m_t >= instr_len(opcode)) m_t = 1;
      else m_t = m_t + 1;
    end
  endtask

  task automatic run_instr(input logic [3:0] op);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b0, op);
      n++;
    end while (m_t != 1 && n < 8);
  endtask

  initial begin
    applyStimulus(1'b1, 4'd0);
    applyStimulus(1'b1, 4'd0);

    run_instr(4'd1);
    run_instr(4'd2);
    run_instr(4'd0);
    run_instr(4'd14);
    run_instr(4'd7);

    // HLT: fetch plus T3, then frozen with everything idle.
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 4'd15);
    applyStimulus(1'b1, 4'd15);
    run_instr(4'd1);

    // Reset lands during T4 of ADD.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd1);
    applyStimulus(1'b1, 4'd1);
    run_instr(4'd2);

    cur_op = 4'd0;
    for (int i = 0; i < 1000; i++) begin
      logic c;
      if (m_t == 1 && !m_halt) cur_op = 4'($urandom_range(0, 15));
      c = ($urandom_range(0, 49) == 0) || (m_halt && $urandom_range(0, 7) == 0);
      applyStimulus(c, cur_op);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
